// File: rtl/fpu_pcx_rcv_ctl.sv
// PCX-to-FPU receive control: a 4-entry in-order request queue that issues to the add/mul/div pipes
// and returns PCX credits. Optional FPU_PCX_RCV_BYPASS_EN adds a 0-cycle issue path when the queue is empty.
module fpu_pcx_rcv_ctl (
    input  logic       rclk,
    input  logic       arst_l,
    input  logic       pcx_fpio_vld,
    input  logic [7:0] pcx_fpio_op,
    input  logic [9:0] pcx_fpio_id,
    input  logic       add_inq_rdy,
    input  logic       mul_inq_rdy,
    input  logic       div_inq_rdy,
    output logic       add_inq_vld,
    output logic       mul_inq_vld,
    output logic       div_inq_vld,
    output logic [7:0] inq_op,
    output logic [9:0] inq_id,
    output logic       fpu_pcx_credit,
    output logic       inq_empty,
    output logic       inq_full,
    output logic       inq_ovf_err,
    output logic       inq_illeg_op
);

    logic [7:0] mem_op [4];
    logic [9:0] mem_id [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    logic [7:0] head_op;
    logic [9:0] head_id;
    logic [1:0] head_cls;
    logic       fifo_empty;
    logic       q_add, q_mul, q_div, q_ill;
    logic       deq_fifo;
    logic       bp_act, bp_add, bp_mul, bp_div, bp_take;
    logic       wr_en;
    logic       ovf_set;

    assign fifo_empty = (count == 3'd0);
    assign head_op    = mem_op[rd_ptr];
    assign head_id    = mem_id[rd_ptr];
    assign head_cls   = head_op[7:6];

    assign q_add = !fifo_empty && (head_cls == 2'b01);
    assign q_mul = !fifo_empty && (head_cls == 2'b10);
    assign q_div = !fifo_empty && (head_cls == 2'b11);
    assign q_ill = !fifo_empty && (head_cls == 2'b00);

    // An illegal head needs no pipe handshake; it is retired on sight.
    assign deq_fifo = (q_add && add_inq_rdy) || (q_mul && mul_inq_rdy) ||
                      (q_div && div_inq_rdy) || q_ill;

`ifdef FPU_PCX_RCV_BYPASS_EN
    logic [1:0] in_cls;
    assign in_cls  = pcx_fpio_op[7:6];
    assign bp_act  = fifo_empty && pcx_fpio_vld && (in_cls != 2'b00);
    assign bp_add  = bp_act && (in_cls == 2'b01);
    assign bp_mul  = bp_act && (in_cls == 2'b10);
    assign bp_div  = bp_act && (in_cls == 2'b11);
    assign bp_take = (bp_add && add_inq_rdy) || (bp_mul && mul_inq_rdy) ||
                     (bp_div && div_inq_rdy);
`else
    assign bp_act  = 1'b0;
    assign bp_add  = 1'b0;
    assign bp_mul  = 1'b0;
    assign bp_div  = 1'b0;
    assign bp_take = 1'b0;
`endif

    // A full queue still accepts when the head leaves in the same cycle.
    assign wr_en   = pcx_fpio_vld && !bp_take && ((count != 3'd4) || deq_fifo);
    assign ovf_set = pcx_fpio_vld && (count == 3'd4) && !deq_fifo;

    assign add_inq_vld  = q_add || bp_add;
    assign mul_inq_vld  = q_mul || bp_mul;
    assign div_inq_vld  = q_div || bp_div;
    assign inq_illeg_op = q_ill;
    assign inq_empty    = fifo_empty;
    assign inq_full     = (count == 3'd4);

    always_comb begin
        inq_op = '0;
        inq_id = '0;
        if (bp_act) begin
            inq_op = pcx_fpio_op;
            inq_id = pcx_fpio_id;
        end else if (!fifo_empty) begin
            inq_op = head_op;
            inq_id = head_id;
        end
    end

    always_ff @(posedge rclk) begin
        if (wr_en) begin
            mem_op[wr_ptr] <= pcx_fpio_op;
            mem_id[wr_ptr] <= pcx_fpio_id;
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            inq_ovf_err    <= 1'b0;
            fpu_pcx_credit <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 2'd1;
            if (deq_fifo)
                rd_ptr <= rd_ptr + 2'd1;
            case ({wr_en, deq_fifo})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (ovf_set)
                inq_ovf_err <= 1'b1;
            fpu_pcx_credit <= deq_fifo || bp_take;
        end
    end

endmodule

// File: tb/tb_fpu_pcx_rcv_ctl.sv
// Directed, table-driven bench for fpu_pcx_rcv_ctl; expectations adapt to FPU_PCX_RCV_BYPASS_EN.
module tb_fpu_pcx_rcv_ctl;

`ifdef FPU_PCX_RCV_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic       rclk = 1'b0;
    logic       arst_l = 1'b0;
    logic       pcx_fpio_vld = 1'b0;
    logic [7:0] pcx_fpio_op = '0;
    logic [9:0] pcx_fpio_id = '0;
    logic       add_inq_rdy = 1'b0;
    logic       mul_inq_rdy = 1'b0;
    logic       div_inq_rdy = 1'b0;
    logic       add_inq_vld, mul_inq_vld, div_inq_vld;
    logic [7:0] inq_op;
    logic [9:0] inq_id;
    logic       fpu_pcx_credit, inq_empty, inq_full, inq_ovf_err, inq_illeg_op;

    fpu_pcx_rcv_ctl dut (
        .rclk           (rclk),
        .arst_l         (arst_l),
        .pcx_fpio_vld   (pcx_fpio_vld),
        .pcx_fpio_op    (pcx_fpio_op),
        .pcx_fpio_id    (pcx_fpio_id),
        .add_inq_rdy    (add_inq_rdy),
        .mul_inq_rdy    (mul_inq_rdy),
        .div_inq_rdy    (div_inq_rdy),
        .add_inq_vld    (add_inq_vld),
        .mul_inq_vld    (mul_inq_vld),
        .div_inq_vld    (div_inq_vld),
        .inq_op         (inq_op),
        .inq_id         (inq_id),
        .fpu_pcx_credit (fpu_pcx_credit),
        .inq_empty      (inq_empty),
        .inq_full       (inq_full),
        .inq_ovf_err    (inq_ovf_err),
        .inq_illeg_op   (inq_illeg_op)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        string      name;
        bit         rst;
        bit         vld;
        logic [7:0] op;
        logic [9:0] id;
        bit         ar, mr, dr;
        logic [25:0] exp;   // {add,mul,div,op,id,credit,empty,full,ovf,illeg}
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic v(input string nm, input bit rst, input bit vld,
                     input logic [7:0] op, input logic [9:0] id,
                     input bit ar, input bit mr, input bit dr,
                     input bit av, input bit mv, input bit dv,
                     input logic [7:0] eop, input logic [9:0] eid,
                     input bit cr, input bit em, input bit fu, input bit ov, input bit il);
        vec_t t;
        t.name = nm; t.rst = rst; t.vld = vld; t.op = op; t.id = id;
        t.ar = ar; t.mr = mr; t.dr = dr;
        t.exp = {av, mv, dv, eop, eid, cr, em, fu, ov, il};
        vecs.push_back(t);
    endtask

    function automatic logic [25:0] snap();
        return {add_inq_vld, mul_inq_vld, div_inq_vld, inq_op, inq_id,
                fpu_pcx_credit, inq_empty, inq_full, inq_ovf_err, inq_illeg_op};
    endfunction

    task automatic check(input string nm, input logic [25:0] got, input logic [25:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        // reset and single add (0-cycle issue with bypass, else 1-cycle)
        v("rst_a", 0,0,8'h00,10'h000,0,0,0, 0,0,0,8'h00,10'h000, 0,1,0,0,0);
        v("rst_b", 0,0,8'h00,10'h000,0,0,0, 0,0,0,8'h00,10'h000, 0,1,0,0,0);
        v("idle0", 1,0,8'h00,10'h000,0,0,0, 0,0,0,8'h00,10'h000, 0,1,0,0,0);
        v("add_arrive", 1,1,8'h41,10'h2A5,1,0,0, BP,0,0, BP ? 8'h41 : 8'h00, BP ? 10'h2A5 : 10'h000, 0,1,0,0,0);
        v("add_issue", 1,0,8'h00,10'h000,1,0,0, !BP,0,0, BP ? 8'h00 : 8'h41, BP ? 10'h000 : 10'h2A5, BP,BP,0,0,0);
        v("add_credit", 1,0,8'h00,10'h000,1,0,0, 0,0,0,8'h00,10'h000, !BP,1,0,0,0);
        v("add_quiet", 1,0,8'h00,10'h000,1,0,0, 0,0,0,8'h00,10'h000, 0,1,0,0,0);
        // fill with mul, overflow, drain in order
        v("mul_w0", 1,1,8'h80,10'h100,0,0,0, 0,BP,0, BP ? 8'h80 : 8'h00, BP ? 10'h100 : 10'h000, 0,1,0,0,0);
        v("mul_w1", 1,1,8'h81,10'h101,0,0,0, 0,1,0,8'h80,10'h100, 0,0,0,0,0);
        v("mul_w2", 1,1,8'h82,10'h102,0,0,0, 0,1,0,8'h80,10'h100, 0,0,0,0,0);
        v("mul_w3", 1,1,8'h83,10'h103,0,0,0, 0,1,0,8'h80,10'h100, 0,0,0,0,0);
        v("mul_ovf", 1,1,8'h84,10'h104,0,0,0, 0,1,0,8'h80,10'h100, 0,0,1,0,0);
        v("ovf_sticky", 1,0,8'h00,10'h000,0,0,0, 0,1,0,8'h80,10'h100, 0,0,1,1,0);
        v("mul_i0", 1,0,8'h00,10'h000,0,1,0, 0,1,0,8'h80,10'h100, 0,0,1,1,0);
        v("mul_i1", 1,0,8'h00,10'h000,0,1,0, 0,1,0,8'h81,10'h101, 1,0,0,1,0);
        v("mul_i2", 1,0,8'h00,10'h000,0,1,0, 0,1,0,8'h82,10'h102, 1,0,0,1,0);
        v("mul_i3", 1,0,8'h00,10'h000,0,1,0, 0,1,0,8'h83,10'h103, 1,0,0,1,0);
        v("mul_cr4", 1,0,8'h00,10'h000,0,1,0, 0,0,0,8'h00,10'h000, 1,1,0,1,0);
        v("mul_quiet", 1,0,8'h00,10'h000,0,0,0, 0,0,0,8'h00,10'h000, 0,1,0,1,0);
        v("ovf_rst", 0,0,8'h00,10'h000,0,0,0, 0,0,0,8'h00,10'h000, 0,1,0,0,0);
        v("ovf_rel", 1,0,8'h00,10'h000,0,0,0, 0,0,0,8'h00,10'h000, 0,1,0,0,0);
        // stalled div blocks a ready add behind it
        v("div_w", 1,1,8'hC0,10'h3C1,1,0,0, 0,0,BP, BP ? 8'hC0 : 8'h00, BP ? 10'h3C1 : 10'h000, 0,1,0,0,0);
        v("add_behind", 1,1,8'h42,10'h042,1,0,0, 0,0,1,8'hC0,10'h3C1, 0,0,0,0,0);
        v("div_stall", 1,0,8'h00,10'h000,1,0,0, 0,0,1,8'hC0,10'h3C1, 0,0,0,0,0);
        v("div_issue", 1,0,8'h00,10'h000,1,0,1, 0,0,1,8'hC0,10'h3C1, 0,0,0,0,0);
        v("add_after", 1,0,8'h00,10'h000,1,0,1, 1,0,0,8'h42,10'h042, 1,0,0,0,0);
        v("cr_after", 1,0,8'h00,10'h000,0,0,0, 0,0,0,8'h00,10'h000, 1,1,0,0,0);
        v("c_quiet", 1,0,8'h00,10'h000,0,0,0, 0,0,0,8'h00,10'h000, 0,1,0,0,0);
        // illegal opcode discarded
        v("ill_w", 1,1,8'h05,10'h155,1,1,1, 0,0,0,8'h00,10'h000, 0,1,0,0,0);
        v("ill_drop", 1,0,8'h00,10'h000,0,0,0, 0,0,0,8'h05,10'h155, 0,0,0,0,1);
        v("ill_cr", 1,0,8'h00,10'h000,0,0,0, 0,0,0,8'h00,10'h000, 1,1,0,0,0);
        v("ill_quiet", 1,0,8'h00,10'h000,0,0,0, 0,0,0,8'h00,10'h000, 0,1,0,0,0);
        // full queue with simultaneous enqueue/dequeue, pointers wrap
        v("add_w0", 1,1,8'h48,10'h200,0,0,0, BP,0,0, BP ? 8'h48 : 8'h00, BP ? 10'h200 : 10'h000, 0,1,0,0,0);
        v("add_w1", 1,1,8'h49,10'h201,0,0,0, 1,0,0,8'h48,10'h200, 0,0,0,0,0);
        v("add_w2", 1,1,8'h4A,10'h202,0,0,0, 1,0,0,8'h48,10'h200, 0,0,0,0,0);
        v("add_w3", 1,1,8'h4B,10'h203,0,0,0, 1,0,0,8'h48,10'h200, 0,0,0,0,0);
        v("full_rw", 1,1,8'h4C,10'h204,1,0,0, 1,0,0,8'h48,10'h200, 0,0,1,0,0);
        v("still_full", 1,0,8'h00,10'h000,0,0,0, 1,0,0,8'h49,10'h201, 1,0,1,0,0);
        v("drain1", 1,0,8'h00,10'h000,1,0,0, 1,0,0,8'h49,10'h201, 0,0,1,0,0);
        v("drain2", 1,0,8'h00,10'h000,1,0,0, 1,0,0,8'h4A,10'h202, 1,0,0,0,0);
        v("drain3", 1,0,8'h00,10'h000,1,0,0, 1,0,0,8'h4B,10'h203, 1,0,0,0,0);
        v("drain4", 1,0,8'h00,10'h000,1,0,0, 1,0,0,8'h4C,10'h204, 1,0,0,0,0);
        v("drain_cr", 1,0,8'h00,10'h000,0,0,0, 0,0,0,8'h00,10'h000, 1,1,0,0,0);
        // reset with 3 entries queued: no credits for discarded entries
        v("q3_w0", 1,1,8'h90,10'h011,0,0,0, 0,BP,0, BP ? 8'h90 : 8'h00, BP ? 10'h011 : 10'h000, 0,1,0,0,0);
        v("q3_w1", 1,1,8'h91,10'h012,0,0,0, 0,1,0,8'h90,10'h011, 0,0,0,0,0);
        v("q3_w2", 1,1,8'h92,10'h013,0,0,0, 0,1,0,8'h90,10'h011, 0,0,0,0,0);
        v("q3_hold", 1,0,8'h00,10'h000,0,0,0, 0,1,0,8'h90,10'h011, 0,0,0,0,0);
        v("q3_rst", 0,0,8'h00,10'h000,0,1,0, 0,0,0,8'h00,10'h000, 0,1,0,0,0);
        v("q3_rel", 1,0,8'h00,10'h000,0,1,0, 0,0,0,8'h00,10'h000, 0,1,0,0,0);
        v("q3_nocr", 1,0,8'h00,10'h000,0,1,0, 0,0,0,8'h00,10'h000, 0,1,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge rclk);
            arst_l       = vecs[i].rst;
            pcx_fpio_vld = vecs[i].vld;
            pcx_fpio_op  = vecs[i].op;
            pcx_fpio_id  = vecs[i].id;
            add_inq_rdy  = vecs[i].ar;
            mul_inq_rdy  = vecs[i].mr;
            div_inq_rdy  = vecs[i].dr;
            #3;
            check(vecs[i].name, snap(), vecs[i].exp);
        end

        // reset asserted mid-cycle, away from any clock edge
        @(negedge rclk);
        mul_inq_rdy = 1'b0; add_inq_rdy = 1'b0; div_inq_rdy = 1'b0;
        pcx_fpio_vld = 1'b1; pcx_fpio_op = 8'hA0; pcx_fpio_id = 10'h0AA;
        @(negedge rclk);
        pcx_fpio_op = 8'hA1; pcx_fpio_id = 10'h0AB;
        @(negedge rclk);
        pcx_fpio_vld = 1'b0; pcx_fpio_op = '0; pcx_fpio_id = '0;
        #1;
        check("async_pre", {mul_inq_vld, inq_id, inq_empty}, {1'b1, 10'h0AA, 1'b0});
        @(posedge rclk);
        #2 arst_l = 1'b0;
        #1;
        check("async_clr", {mul_inq_vld, inq_id, inq_empty, inq_full}, {1'b0, 10'h000, 1'b1, 1'b0});
        @(negedge rclk);
        arst_l = 1'b1;
        mul_inq_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge rclk);
            #1;
            check("async_nocr", {fpu_pcx_credit, mul_inq_vld, inq_empty}, {1'b0, 1'b0, 1'b1});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpu_pcx_rcv_ctl.md
FPU_PCX_RCV_CTL -- requirements
Module: fpu_pcx_rcv_ctl

Interface
REQ-001 SHALL have port rclk, input, 1, the single global clock; all flops sample on its rising edge.
REQ-002 SHALL have port arst_l, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port pcx_fpio_vld, input, 1, request from PCX valid this cycle.
REQ-004 SHALL have port pcx_fpio_op, input, 8, opcode; bits [7:6] give the class: 01 add, 10 mul, 11 div, 00 illegal.
REQ-005 SHALL have port pcx_fpio_id, input, 10, result ID: [9:2] CQ tag, [1:0] thread.
REQ-006 SHALL have ports add_inq_rdy, mul_inq_rdy, div_inq_rdy, input, 1 each, meaning the pipe accepts an issue this cycle.
REQ-007 SHALL have ports add_inq_vld, mul_inq_vld, div_inq_vld, output, 1 each, issue valid to that pipe.
REQ-008 SHALL have port inq_op, output, 8, opcode of the issuing entry.
REQ-009 SHALL have port inq_id, output, 10, ID of the issuing entry; returned later on the result path.
REQ-010 SHALL have port fpu_pcx_credit, output, 1, one-cycle credit-return pulse to PCX.
REQ-011 SHALL have ports inq_empty and inq_full, output, 1 each, queue status.
REQ-012 SHALL have port inq_ovf_err, output, 1, sticky overflow error.
REQ-013 SHALL have port inq_illeg_op, output, 1, one-cycle pulse when an illegal opcode is discarded.

Function
REQ-014 SHALL hold a 4-entry in-order FIFO of {op, id}, with 2-bit read and write pointers plus a 3-bit count.
REQ-015 SHALL write pcx_fpio_op and pcx_fpio_id into the FIFO on any cycle with pcx_fpio_vld=1 and count<4, or count=4 with a same-cycle dequeue.
REQ-016 SHALL drop the write and set inq_ovf_err on pcx_fpio_vld=1 with count=4 and no same-cycle dequeue; inq_ovf_err holds until reset.
REQ-017 SHALL decode only the head entry; exactly one of add_inq_vld, mul_inq_vld, div_inq_vld is 1 when the head is a legal class, and all are 0 when the FIFO is empty.
REQ-018 SHALL drive inq_op and inq_id from the head entry; when the FIFO is empty they SHALL be 0.
REQ-019 SHALL dequeue the head on the cycle its target pipe has vld=1 and rdy=1.
REQ-020 SHALL NOT issue a younger entry past a stalled head (no reordering).
REQ-021 SHALL, for an illegal head (class 00), assert no pipe valid, dequeue it in one cycle, and pulse inq_illeg_op in that same cycle.
REQ-022 SHALL pulse fpu_pcx_credit, registered, exactly one cycle after every dequeue, legal or illegal; PCX starts with 4 credits.
REQ-023 SHALL support a simultaneous enqueue and dequeue, leaving count unchanged.
REQ-024 SHALL wrap pointers modulo 4.
REQ-025 SHALL drive inq_empty = (count==0) and inq_full = (count==4), both combinational from count.

Reset
REQ-026 SHALL, while arst_l=0 (asserted asynchronously, deasserted on a rclk edge), clear pointers and count, clear inq_ovf_err and fpu_pcx_credit, and drive all pipe valids and inq_illeg_op to 0, inq_empty to 1 and inq_full to 0.
REQ-027 SHALL discard all queued entries on reset mid-operation, with no credit returned for them; PCX re-initialises its credits on the same reset.

Configuration
REQ-028 SHALL use macro FPU_PCX_RCV_BYPASS_EN; when it is defined and the FIFO is empty, an arriving legal request SHALL drive its pipe valid, inq_op and inq_id combinationally in the arrival cycle, and SHALL NOT be written if the pipe accepts (0-cycle latency, credit pulse the next cycle).
REQ-029 SHALL, without FPU_PCX_RCV_BYPASS_EN, issue a request no earlier than the cycle after it is written (minimum 1-cycle latency).

Verification
REQ-030 SHALL cover: reset, then vld with op=8'h41 and id=10'h2A5 while add_inq_rdy=1 -> add_inq_vld=1, inq_id=10'h2A5 at cycle+1 (cycle+0 with the macro); credit pulses the following cycle.
REQ-031 SHALL cover: 4 mul ops with mul_inq_rdy=0, then a 5th vld -> inq_full=1, inq_ovf_err=1 sticky; on rdy=1, the 4 ops issue in order and produce 4 credits.
REQ-032 SHALL cover: head div with div_inq_rdy=0 and an add behind it with add_inq_rdy=1 -> add_inq_vld=0 until the div issues.
REQ-033 SHALL cover: op=8'h05 (illegal) -> inq_illeg_op pulse, no pipe valid, credit next cycle, inq_empty=1.
REQ-034 SHALL cover: count=4 with a dequeue and vld in the same cycle -> no overflow, count stays 4, pointers wrap correctly.
REQ-035 SHALL cover: arst_l pulsed low with 3 entries queued -> immediate inq_empty=1, all valids 0, no credit pulses.
